// File: rtl/instr_pkg.sv
// Shared RV32I encoding constants, the instruction-class enum and immediate
// range limits used by the instruction encoder.
package instr_pkg;

    typedef enum logic [3:0] {
        FMT_R      = 4'd0,
        FMT_I      = 4'd1,
        FMT_SHIFT  = 4'd2,
        FMT_LOAD   = 4'd3,
        FMT_STORE  = 4'd4,
        FMT_BRANCH = 4'd5,
        FMT_JAL    = 4'd6,
        FMT_JALR   = 4'd7,
        FMT_LUI    = 4'd8
    } fmt_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int BR_MIN    = -4096;
    localparam int BR_MAX    = 4094;
    localparam int JAL_MIN   = -1048576;
    localparam int JAL_MAX   = 1048574;
    localparam int LUI_MAX   = 1048575;

    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV32I instruction fields into 32-bit words, range-checks immediates
// and buffers legal words for sequential writes into instruction memory.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3:0]              i_fmt,
    input  logic [2:0]              i_funct3,
    input  logic                    i_alt,
    input  logic [4:0]              i_rd,
    input  logic [4:0]              i_rs1,
    input  logic [4:0]              i_rs2,
    input  logic [31:0]             i_imm,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [31:0]             o_wr_data,
    input  logic                    i_wr_ready,
    output logic                    o_err,
    output logic [$clog2(DEPTH):0]  o_level
);
    fmt_e               fmt;
    logic signed [31:0] simm;
    logic [31:0]        word;
    logic               legal;
    logic               ready_q;
    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               pop;

    assign fmt  = fmt_e'(i_fmt);
    assign simm = $signed(i_imm);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {(i_alt ? F7_ALT : F7_BASE), i_rs2, i_rs1, i_funct3, i_rd, OP_R};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
                legal = in_range(simm, IMM12_MIN, IMM12_MAX);
            end
            FMT_SHIFT: begin
                word  = {1'b0, i_alt, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_I};
                legal = in_range(simm, 0, SHAMT_MAX);
            end
            FMT_LOAD: begin
                word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
                legal = in_range(simm, IMM12_MIN, IMM12_MAX);
            end
            FMT_STORE: begin
                word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
                legal = in_range(simm, IMM12_MIN, IMM12_MAX);
            end
            FMT_BRANCH: begin
                word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], OP_BRANCH};
                legal = in_range(simm, BR_MIN, BR_MAX) && !i_imm[0];
            end
            FMT_JAL: begin
                word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                legal = in_range(simm, JAL_MIN, JAL_MAX) && !i_imm[0];
            end
            FMT_JALR: begin
                word  = {i_imm[11:0], i_rs1, F3_JALR, i_rd, OP_JALR};
                legal = in_range(simm, IMM12_MIN, IMM12_MAX);
            end
            FMT_LUI: begin
                word  = {i_imm[19:0], i_rd, OP_LUI};
                legal = in_range(simm, 0, LUI_MAX);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // ready_q holds o_ready low during reset and raises it on the first edge after.
    assign o_ready = ready_q & ~full;
    assign accept  = i_valid & o_ready;
    assign push    = accept & legal & ~i_clear;
    assign pop     = o_wr_en & i_wr_ready & ~i_clear;
    assign o_wr_en = ~empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ready_q   <= 1'b0;
            o_wr_addr <= ADDR_W'(BASE_ADDR);
            o_err     <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (i_clear) begin
                o_wr_addr <= ADDR_W'(BASE_ADDR);
                o_err     <= 1'b0;
            end else begin
                if (pop)             o_wr_addr <= o_wr_addr + 1'b1;
                if (accept && !legal) o_err    <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .clear (i_clear),
        .push  (push),
        .pop   (pop),
        .din   (word),
        .dout  (o_wr_data),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range errors, backpressure,
// address wrap (second instance) and reset/clear behaviour.
module tb_instr_encoder;
    import instr_pkg::*;

    localparam int DEPTH = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_valid = 1'b0;
    logic [3:0]  i_fmt = 4'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic        i_alt = 1'b0;
    logic [4:0]  i_rd = 5'd0;
    logic [4:0]  i_rs1 = 5'd0;
    logic [4:0]  i_rs2 = 5'd0;
    logic [31:0] i_imm = 32'd0;
    logic        i_wr_ready = 1'b0;

    logic        o_ready, o_wr_en, o_err;
    logic [9:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic [3:0]  o_level;

    logic        w_ready, w_wr_en, w_err;
    logic [1:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [3:0]  w_level;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_data_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wrap_addr_q[$];

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid),
        .o_ready(o_ready), .i_fmt(i_fmt), .i_funct3(i_funct3), .i_alt(i_alt),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .i_wr_ready(i_wr_ready), .o_err(o_err), .o_level(o_level)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(3)) dut_wrap (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid),
        .o_ready(w_ready), .i_fmt(i_fmt), .i_funct3(i_funct3), .i_alt(i_alt),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_wr_en(w_wr_en), .o_wr_addr(w_wr_addr), .o_wr_data(w_wr_data),
        .i_wr_ready(i_wr_ready), .o_err(w_err), .o_level(w_level)
    );

    // clock / watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // write monitor: inputs are stable from posedge+1 to the next posedge
    always @(negedge i_clk) begin
        if (!i_reset && !i_clear && i_wr_ready) begin
            if (o_wr_en) begin
                wr_data_q.push_back(o_wr_data);
                wr_addr_q.push_back(32'(o_wr_addr));
            end
            if (w_wr_en) wrap_addr_q.push_back(32'(w_wr_addr));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_queues();
        wr_data_q.delete();
        wr_addr_q.delete();
        wrap_addr_q.delete();
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic set_instr(input logic [3:0] fmt, input logic [2:0] f3, input logic alt,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm);
        i_fmt = fmt; i_funct3 = f3; i_alt = alt;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    endtask

    task automatic send(input logic [3:0] fmt, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n;
        n = 0;
        set_instr(fmt, f3, alt, rd, rs1, rs2, imm);
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            n++;
            @(negedge i_clk);
        end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: o_ready=%0b required 1", o_ready);
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((o_level != 0 || o_wr_en) && n < 100) begin
            tick();
            n++;
        end
        if (o_level != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: o_level=%0d required 0", o_level);
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", o_level); end
        checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b required 0", o_wr_en); end
        checks++; if (o_wr_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", o_wr_addr); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", o_err); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b required 0", o_ready); end
        i_reset = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %0b required 0", o_ready); end
        tick();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %0b required 1", o_ready); end
    endtask

    task automatic test_encoding();
        logic [31:0] exp_d[4];
        exp_d = '{32'h00500093, 32'h002081B3, 32'h0020A223, 32'h00208463};
        clear_queues();
        i_wr_ready = 1'b1;
        send(FMT_I,      3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        checks++; if (o_level !== 4'd1) begin errors++; $display("FAIL enc_level0: got %0d required 1", o_level); end
        send(FMT_R,      3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        checks++; if (o_level !== 4'd1) begin errors++; $display("FAIL enc_level_pushpop: got %0d required 1", o_level); end
        send(FMT_STORE,  3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
        send(FMT_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        wait_drain();
        checks++; if (wr_data_q.size() != 4) begin errors++; $display("FAIL enc_count: got %0d required 4", wr_data_q.size()); end
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== exp_d[i]) begin errors++; $display("FAIL enc_data[%0d]: got %08h required %08h", i, wr_data_q[i], exp_d[i]); end
            checks++;
            if (wr_addr_q[i] !== 32'(i)) begin errors++; $display("FAIL enc_addr[%0d]: got %0d required %0d", i, wr_addr_q[i], i); end
        end
    endtask

    task automatic test_wrap();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
        clear_queues();
        i_wr_ready = 1'b1;
        send(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2);
        wait_drain();
        checks++; if (wrap_addr_q.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d required 2", wrap_addr_q.size()); end
        if (wrap_addr_q.size() == 2) begin
            checks++; if (wrap_addr_q[0] !== 32'd3) begin errors++; $display("FAIL wrap_addr0: got %0d required 3", wrap_addr_q[0]); end
            checks++; if (wrap_addr_q[1] !== 32'd0) begin errors++; $display("FAIL wrap_addr1: got %0d required 0", wrap_addr_q[1]); end
        end
        checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %0b required 0", w_err); end
    endtask

    task automatic test_jump();
        logic [31:0] exp_d[3];
        exp_d = '{32'h001000EF, 32'h123452B7, 32'h4030D093};
        clear_queues();
        i_wr_ready = 1'b1;
        send(FMT_JAL,   3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(FMT_LUI,   3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345);
        send(FMT_SHIFT, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        wait_drain();
        checks++; if (wr_data_q.size() != 3) begin errors++; $display("FAIL jump_count: got %0d required 3", wr_data_q.size()); end
        for (int i = 0; i < 3 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== exp_d[i]) begin errors++; $display("FAIL jump_data[%0d]: got %08h required %08h", i, wr_data_q[i], exp_d[i]); end
        end
    endtask

    task automatic test_range();
        pulse_clear();
        clear_queues();
        i_wr_ready = 1'b1;
        send(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL range_err_set: got %0b required 1", o_err); end
        checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL range_discard: got %0d required 0", o_level); end
        send(FMT_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7);
        send(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        wait_drain();
        checks++; if (wr_data_q.size() != 1) begin errors++; $display("FAIL range_count: got %0d required 1", wr_data_q.size()); end
        if (wr_data_q.size() == 1) begin
            checks++; if (wr_data_q[0] !== 32'h00500093) begin errors++; $display("FAIL range_data: got %08h required 00500093", wr_data_q[0]); end
            checks++; if (wr_addr_q[0] !== 32'd0) begin errors++; $display("FAIL range_addr: got %0d required 0", wr_addr_q[0]); end
        end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL range_err_sticky: got %0b required 1", o_err); end
        pulse_clear();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL clear_err: got %0b required 0", o_err); end
        send(4'hF, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL bad_fmt_err: got %0b required 1", o_err); end
        checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL bad_fmt_discard: got %0d required 0", o_level); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        int acc;
        acc = 0;
        pulse_clear();
        clear_queues();
        i_wr_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            set_instr(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k));
            i_valid = 1'b1;
            @(negedge i_clk);
            if (o_ready) begin
                acc++;
                exp_q.push_back(32'h00000093 | (32'(k) << 20));
            end
            tick();
        end
        i_valid = 1'b0;
        checks++; if (acc != DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d required %0d", acc, DEPTH); end
        checks++; if (o_level !== 4'(DEPTH)) begin errors++; $display("FAIL bp_level: got %0d required %0d", o_level, DEPTH); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0b required 0", o_ready); end
        i_wr_ready = 1'b1;
        @(negedge i_clk);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_pop_cycle: got %0b required 0", o_ready); end
        tick();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %0b required 1", o_ready); end
        wait_drain();
        checks++; if (wr_data_q.size() != DEPTH) begin errors++; $display("FAIL bp_count: got %0d required %0d", wr_data_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %08h required %08h", i, wr_data_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        i_wr_ready = 1'b1;
        send(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd9);
        wait_drain();
        i_wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'(k));
        checks++; if (o_level !== 4'd3) begin errors++; $display("FAIL mid_level_pre: got %0d required 3", o_level); end
        i_reset = 1'b1;
        #1;
        checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en: got %0b required 0", o_wr_en); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %0b required 0", o_ready); end
        tick();
        i_reset = 1'b0;
        tick();
        checks++; if (o_wr_addr !== 10'd0) begin errors++; $display("FAIL mid_addr: got %0d required 0", o_wr_addr); end
        checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL mid_level: got %0d required 0", o_level); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %0b required 1", o_ready); end
    endtask

    task automatic test_clear();
        i_wr_ready = 1'b1;
        send(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1);
        wait_drain();
        send(4'hF, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        i_wr_ready = 1'b0;
        send(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        send(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd3);
        checks++; if (o_wr_addr !== 10'd1) begin errors++; $display("FAIL clr_addr_pre: got %0d required 1", o_wr_addr); end
        set_instr(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd4);
        i_valid = 1'b1;
        i_wr_ready = 1'b1;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_wr_ready = 1'b0;
        checks++; if (o_level !== 4'd0) begin errors++; $display("FAIL clr_level: got %0d required 0", o_level); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %0b required 0", o_err); end
        checks++; if (o_wr_addr !== 10'd0) begin errors++; $display("FAIL clr_addr: got %0d required 0", o_wr_addr); end
        checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL clr_wr_en: got %0b required 0", o_wr_en); end
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_wrap();
        test_jump();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
